writeback_stage: RTL and testbench

Writeback stage of the Y86-64 pipeline: holds the W pipeline register, owns the 15-entry × 64-bit architectural register file, and commits `valE`/`valM` results on the clock edge. It is the write side of the register-file interface that the decode stage reads. The W-register contents are also exported so the decode stage can forward from them. It also produces the processor status and a sticky halt flag.

---
 rtl/writeback_if.sv | 46 ++++
 rtl/writeback_stage.sv | 121 ++++++++++++
 tb/tb_writeback_stage.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/writeback_if.sv
// ============================================================================
// Module      : writeback_if
// Description : W-stage bundle: M-side inputs, W-register export, regfile reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface writeback_if;
  logic        W_stall;
  logic        W_bubble;
  logic [3:0]  m_stat;
  logic [3:0]  M_icode;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic [63:0] M_valE;
  logic [63:0] m_valM;
  logic [3:0]  W_stat;
  logic [3:0]  W_icode;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] valStk;
  logic [3:0]  stat;
  logic        halted;

  modport master (
    output W_stall, W_bubble, m_stat, M_icode, M_dstE, M_dstM, M_valE, m_valM,
    output srcA, srcB,
    input  W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM,
    input  valA, valB, valStk, stat, halted
  );

  modport slave (
    input  W_stall, W_bubble, m_stat, M_icode, M_dstE, M_dstM, M_valE, m_valM,
    input  srcA, srcB,
    output W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM,
    output valA, valB, valStk, stat, halted
  );
endinterface

`default_nettype wire

// File: rtl/writeback_stage.sv
// ============================================================================
// Module      : writeback_stage
// Description : Y86-64 writeback: W pipeline register, 15x64 register file,
//               processor status and sticky halt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_stage #(
  parameter logic [63:0] RSP_RESET = 64'h0,
  parameter logic [3:0]  AOK       = 4'd1,
  parameter logic [3:0]  HLT       = 4'd2,
  parameter logic [3:0]  ADR       = 4'd3,
  parameter logic [3:0]  INS       = 4'd4
) (
  input  wire logic   clk,
  input  wire logic   rst,
  writeback_if.slave  wb_io
);

  localparam logic [3:0] c_REG_NONE = 4'hF;
  localparam logic [3:0] c_NOP      = 4'h1;

  logic [3:0]  W_stat_q,  W_stat_d;
  logic [3:0]  W_icode_q, W_icode_d;
  logic [3:0]  W_dstE_q,  W_dstE_d;
  logic [3:0]  W_dstM_q,  W_dstM_d;
  logic [63:0] W_valE_q,  W_valE_d;
  logic [63:0] W_valM_q,  W_valM_d;
  logic        halted_q,  halted_d;
  logic        w_commit;

  // Read mux: slot 15 is the "no register" ID and always reads as zero.
  logic [15:0][63:0] w_rd;

  always_comb begin
    W_stat_d  = W_stat_q;
    W_icode_d = W_icode_q;
    W_dstE_d  = W_dstE_q;
    W_dstM_d  = W_dstM_q;
    W_valE_d  = W_valE_q;
    W_valM_d  = W_valM_q;
    if (wb_io.W_bubble) begin
      W_stat_d  = AOK;
      W_icode_d = c_NOP;
      W_dstE_d  = c_REG_NONE;
      W_dstM_d  = c_REG_NONE;
      W_valE_d  = 64'h0;
      W_valM_d  = 64'h0;
    end else if (!wb_io.W_stall && !halted_q) begin
      W_stat_d  = wb_io.m_stat;
      W_icode_d = wb_io.M_icode;
      W_dstE_d  = wb_io.M_dstE;
      W_dstM_d  = wb_io.M_dstM;
      W_valE_d  = wb_io.M_valE;
      W_valM_d  = wb_io.m_valM;
    end
  end

  // The faulting instruction's own writes are dropped at the edge that halts.
  assign w_commit = (W_stat_q == AOK) && !halted_q;
  assign halted_d = halted_q || (W_stat_q != AOK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      W_stat_q  <= AOK;
      W_icode_q <= c_NOP;
      W_dstE_q  <= c_REG_NONE;
      W_dstM_q  <= c_REG_NONE;
      W_valE_q  <= 64'h0;
      W_valM_q  <= 64'h0;
      halted_q  <= 1'b0;
    end else begin
      W_stat_q  <= W_stat_d;
      W_icode_q <= W_icode_d;
      W_dstE_q  <= W_dstE_d;
      W_dstM_q  <= W_dstM_d;
      W_valE_q  <= W_valE_d;
      W_valM_q  <= W_valM_d;
      halted_q  <= halted_d;
    end
  end

  for (genvar i = 0; i < 15; i++) begin : g_rf
    localparam logic [3:0]  c_IDX = 4'(i);
    localparam logic [63:0] c_RST = (i == 14) ? RSP_RESET : 64'h0;

    logic [63:0] rf_q, rf_d;

    // M port checked last so it overrides E when both target this entry.
    always_comb begin
      rf_d = rf_q;
      if (w_commit && (W_dstE_q == c_IDX)) rf_d = W_valE_q;
      if (w_commit && (W_dstM_q == c_IDX)) rf_d = W_valM_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) rf_q <= c_RST;
      else     rf_q <= rf_d;
    end

    assign w_rd[i] = rf_q;
  end

  assign w_rd[15] = 64'h0;

  assign wb_io.valA    = w_rd[wb_io.srcA];
  assign wb_io.valB    = w_rd[wb_io.srcB];
  assign wb_io.valStk  = w_rd[14];
  assign wb_io.stat    = W_stat_q;
  assign wb_io.halted  = halted_q;
  assign wb_io.W_stat  = W_stat_q;
  assign wb_io.W_icode = W_icode_q;
  assign wb_io.W_dstE  = W_dstE_q;
  assign wb_io.W_dstM  = W_dstM_q;
  assign wb_io.W_valE  = W_valE_q;
  assign wb_io.W_valM  = W_valM_q;

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
// ============================================================================
// Module      : tb_writeback_stage
// Description : Directed self-checking bench for writeback_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_writeback_stage;

  localparam logic [63:0] c_RSP = 64'h0000_0000_0000_0100;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  writeback_if u_if ();

  writeback_stage #(
    .RSP_RESET (c_RSP)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .wb_io (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One active edge, then settle to the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_m(input logic [3:0] st, input logic [3:0] ic,
                         input logic [3:0] de, input logic [3:0] dm,
                         input logic [63:0] ve, input logic [63:0] vm);
    u_if.m_stat  = st;
    u_if.M_icode = ic;
    u_if.M_dstE  = de;
    u_if.M_dstM  = dm;
    u_if.M_valE  = ve;
    u_if.m_valM  = vm;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    u_if.W_stall  = 1'b0;
    u_if.W_bubble = 1'b0;
    u_if.srcA     = 4'd3;
    u_if.srcB     = 4'd0;
    drive_m(4'd1, 4'd1, 4'hF, 4'hF, 64'h0, 64'h0);
    step();
    rst = 1'b0;
    step();

    // Mid-cycle asynchronous reset
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_valStk", u_if.valStk, c_RSP);
    chk("rst_valA",   u_if.valA, 64'h0);
    chk("rst_icode",  {60'h0, u_if.W_icode}, 64'h1);
    chk("rst_dstE",   {60'h0, u_if.W_dstE}, 64'hF);
    chk("rst_stat",   {60'h0, u_if.stat}, 64'h1);
    chk("rst_halted", {63'h0, u_if.halted}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Two-edge commit of an E result into reg 2
    u_if.srcA = 4'd2;
    drive_m(4'd1, 4'd3, 4'd2, 4'hF, 64'h1234, 64'h0);
    step();
    chk("commit_WvalE", u_if.W_valE, 64'h1234);
    chk("commit_WdstE", {60'h0, u_if.W_dstE}, 64'h2);
    chk("commit_early", u_if.valA, 64'h0);
    drive_m(4'd1, 4'd1, 4'hF, 4'hF, 64'h0, 64'h0);
    step();
    chk("commit_valA", u_if.valA, 64'h1234);

    // Both ports to reg 14: M wins
    drive_m(4'd1, 4'hB, 4'd14, 4'd14, 64'h8, 64'hAA);
    step();
    drive_m(4'd1, 4'd1, 4'hF, 4'hF, 64'h0, 64'h0);
    step();
    chk("dual_valStk", u_if.valStk, 64'hAA);

    // Both ports to different registers
    u_if.srcA = 4'd4;
    u_if.srcB = 4'd6;
    drive_m(4'd1, 4'hB, 4'd4, 4'd6, 64'h9, 64'h66);
    step();
    drive_m(4'd1, 4'd1, 4'hF, 4'hF, 64'h0, 64'h0);
    step();
    chk("split_E", u_if.valA, 64'h9);
    chk("split_M", u_if.valB, 64'h66);

    // Stall holds the W register
    u_if.W_stall = 1'b1;
    drive_m(4'd1, 4'd3, 4'd7, 4'hF, 64'h77, 64'h0);
    step();
    chk("stall_icode", {60'h0, u_if.W_icode}, 64'h1);
    chk("stall_dstE",  {60'h0, u_if.W_dstE}, 64'hF);
    u_if.W_stall = 1'b0;
    drive_m(4'd1, 4'd3, 4'hF, 4'hF, 64'h77, 64'h0);
    step();
    chk("load_icode", {60'h0, u_if.W_icode}, 64'h3);
    chk("load_valE",  u_if.W_valE, 64'h77);

    // Bubble beats stall
    u_if.W_stall  = 1'b1;
    u_if.W_bubble = 1'b1;
    drive_m(4'd1, 4'd3, 4'd7, 4'hF, 64'h77, 64'h0);
    step();
    chk("bub_icode", {60'h0, u_if.W_icode}, 64'h1);
    chk("bub_dstE",  {60'h0, u_if.W_dstE}, 64'hF);
    chk("bub_valE",  u_if.W_valE, 64'h0);
    u_if.W_stall  = 1'b0;
    u_if.W_bubble = 1'b0;
    drive_m(4'd1, 4'd1, 4'hF, 4'hF, 64'h0, 64'h0);
    u_if.srcA = 4'd7;
    step();
    chk("bub_reg7", u_if.valA, 64'h0);

    // Halt: writes of the HLT instruction suppressed, then everything frozen
    u_if.srcA = 4'd5;
    u_if.srcB = 4'd2;
    drive_m(4'd2, 4'd0, 4'd5, 4'hF, 64'h7, 64'h0);
    step();
    chk("hlt_stat1",   {60'h0, u_if.stat}, 64'h2);
    chk("hlt_early",   {63'h0, u_if.halted}, 64'h0);
    step();
    chk("hlt_halted",  {63'h0, u_if.halted}, 64'h1);
    chk("hlt_stat2",   {60'h0, u_if.stat}, 64'h2);
    chk("hlt_reg5",    u_if.valA, 64'h0);
    drive_m(4'd1, 4'd3, 4'd5, 4'hF, 64'h9, 64'h0);
    step();
    step();
    chk("frz_halted", {63'h0, u_if.halted}, 64'h1);
    chk("frz_icode",  {60'h0, u_if.W_icode}, 64'h0);
    chk("frz_valE",   u_if.W_valE, 64'h7);
    chk("frz_reg5",   u_if.valA, 64'h0);
    chk("frz_reg2",   u_if.valB, 64'h1234);

    // Reset mid-operation clears halt and the register file
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst2_halted", {63'h0, u_if.halted}, 64'h0);
    chk("rst2_valStk", u_if.valStk, c_RSP);
    chk("rst2_reg2",   u_if.valB, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
